adder_reservation_stations: RTL and testbench

Tomasulo-style reservation-station bank for the adder unit, directly downstream of the instruction queue. Accepts issued instructions and reads source registers through the register-file read ports. Renames destinations in an internal register status table and captures pending operands from the common data bus (CDB). Dispatches ready entries to the adder and reports per-station progress back to the queue.

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_entry.sv | 84 ++++++++
 rtl/adder_reservation_stations.sv | 240 ++++++++++++++++++++++++
 tb/tb_adder_reservation_stations.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the adder reservation-station bank.
// Tags are one-hot; station k owns tag bit k.
package rs_pkg;

  localparam int TAG_W = 6;

  localparam logic [2:0] UNIT_ADDER = 3'b000;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    READY,
    EXEC
  } rs_state_e;

endpackage

// File: rtl/rs_entry.sv
// One adder reservation station: operand capture, CDB snoop and
// the FREE -> WAIT/READY -> EXEC -> FREE lifecycle.
module rs_entry
  import rs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic [2:0]        alloc_op,
  input  logic [DATA_W-1:0] alloc_vj,
  input  logic [DATA_W-1:0] alloc_vk,
  input  logic [TAG_W-1:0]  alloc_qj,
  input  logic [TAG_W-1:0]  alloc_qk,
  input  logic              grant,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              is_free,
  output logic              is_ready,
  output logic              done,
  output logic [2:0]        op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  localparam logic [TAG_W-1:0] OWN = TAG_W'(1) << IDX;

  rs_state_e        state;
  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;
  logic             hit_j;
  logic             hit_k;

  assign hit_j    = cdb_valid && (qj != '0) && (qj == cdb_tag);
  assign hit_k    = cdb_valid && (qk != '0) && (qk == cdb_tag);
  assign done     = cdb_valid && (state == EXEC) && (cdb_tag == OWN);
  assign is_free  = (state == FREE);
  assign is_ready = (state == READY);

  // Lifecycle: load on allocation, wake on CDB, release on own result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FREE;
      op    <= '0;
      vj    <= '0;
      vk    <= '0;
      qj    <= '0;
      qk    <= '0;
    end else begin
      case (state)
        FREE: begin
          if (alloc) begin
            op <= alloc_op;
            vj <= alloc_vj;
            vk <= alloc_vk;
            qj <= alloc_qj;
            qk <= alloc_qk;
            if (alloc_qj == '0 && alloc_qk == '0) state <= READY;
            else state <= WAIT;
          end
        end
        WAIT: begin
          if (hit_j) begin
            vj <= cdb_value;
            qj <= '0;
          end
          if (hit_k) begin
            vk <= cdb_value;
            qk <= '0;
          end
          if ((qj == '0 || hit_j) && (qk == '0 || hit_k))
            state <= READY;
        end
        READY: if (grant) state <= EXEC;
        EXEC:  if (done) state <= FREE;
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: rtl/adder_reservation_stations.sv
// Adder reservation-station bank: allocator, status table, dispatch.
// ADDER_RS_AGE_EN: dispatch oldest READY station, else lowest index.
module adder_reservation_stations
  import rs_pkg::*;
#(
  parameter int NUM_RS   = 3,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [5:0]        operation,
  input  logic [4:0]        Dest_address,
  input  logic [4:0]        A_address,
  input  logic [4:0]        B_address,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  input  logic              cdb_valid,
  input  logic [5:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              adder_ready,
  output logic              adder_start,
  output logic [2:0]        adder_op,
  output logic [DATA_W-1:0] adder_a,
  output logic [DATA_W-1:0] adder_b,
  output logic [5:0]        adder_tag,
  output logic              adder_available,
  output logic [5:0]        adder_RS_available,
  output logic [5:0]        RS_issued,
  output logic [5:0]        RS_executing_adder,
  output logic [5:0]        RS_finished,
  output logic              issue_error
);

  logic [NUM_RS-1:0] free_v;
  logic [NUM_RS-1:0] ready_v;
  logic [NUM_RS-1:0] done_v;
  logic [NUM_RS-1:0] alloc_v;
  logic [NUM_RS-1:0] sel_oh;
  logic [NUM_RS-1:0] grant_v;
  logic [2:0]        ent_op [NUM_RS];
  logic [DATA_W-1:0] ent_vj [NUM_RS];
  logic [DATA_W-1:0] ent_vk [NUM_RS];

  logic [TAG_W-1:0]  status [NUM_REGS];
  logic [TAG_W-1:0]  free_tag;
  logic [TAG_W-1:0]  st_a;
  logic [TAG_W-1:0]  st_b;
  logic [TAG_W-1:0]  qj_in;
  logic [TAG_W-1:0]  qk_in;
  logic [DATA_W-1:0] vj_in;
  logic [DATA_W-1:0] vk_in;
  logic              accept;
  logic              reject;
  logic              sel_any;
  logic [2:0]        d_op;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;

  for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
    rs_entry #(
      .DATA_W (DATA_W),
      .IDX    (k)
    ) u_rs (
      .clock     (clock),
      .reset     (reset),
      .alloc     (alloc_v[k]),
      .alloc_op  (operation[2:0]),
      .alloc_vj  (vj_in),
      .alloc_vk  (vk_in),
      .alloc_qj  (qj_in),
      .alloc_qk  (qk_in),
      .grant     (grant_v[k]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .is_free   (free_v[k]),
      .is_ready  (ready_v[k]),
      .done      (done_v[k]),
      .op        (ent_op[k]),
      .vj        (ent_vj[k]),
      .vk        (ent_vk[k])
    );
  end

  // Lowest free station is the next allocation target
  always_comb begin
    free_tag = '0;
    for (int k = NUM_RS - 1; k >= 0; k--)
      if (free_v[k]) free_tag = TAG_W'(1) << k;
  end

  assign adder_available    = |free_v;
  assign adder_RS_available = free_tag;
  assign accept  = issue && (operation[5:3] == UNIT_ADDER) && (|free_v);
  assign reject  = issue && !accept;
  assign alloc_v = accept ? free_tag[NUM_RS-1:0] : '0;

  // Source operands: register file, pending tag, or same-cycle CDB bypass
  always_comb begin
    st_a  = status[A_address];
    st_b  = status[B_address];
    vj_in = rf_a_data;
    qj_in = '0;
    vk_in = rf_b_data;
    qk_in = '0;
    if (st_a != '0) begin
      if (cdb_valid && cdb_tag == st_a) begin
        vj_in = cdb_value;
      end else begin
        vj_in = '0;
        qj_in = st_a;
      end
    end
    if (st_b != '0) begin
      if (cdb_valid && cdb_tag == st_b) begin
        vk_in = cdb_value;
      end else begin
        vk_in = '0;
        qk_in = st_b;
      end
    end
  end

`ifdef ADDER_RS_AGE_EN
  localparam int AGE_W = $clog2(NUM_RS) + 1;

  logic [AGE_W-1:0] age [NUM_RS];
  logic [AGE_W-1:0] best;
  logic [AGE_W-1:0] busy_cnt;
  logic [AGE_W-1:0] gone_age;
  logic             gone;

  // Age is the rank among occupied stations; 0 is the oldest
  always_comb begin
    busy_cnt = '0;
    gone     = 1'b0;
    gone_age = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (!free_v[k] && !done_v[k]) busy_cnt = busy_cnt + AGE_W'(1);
      if (done_v[k]) begin
        gone     = 1'b1;
        gone_age = age[k];
      end
    end
  end

  // New stations rank behind survivors; a departure closes the gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_RS; k++) age[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_RS; k++) begin
        if (alloc_v[k])
          age[k] <= busy_cnt;
        else if (gone && !free_v[k] && age[k] > gone_age)
          age[k] <= age[k] - AGE_W'(1);
      end
    end
  end
`endif

  // Dispatch select and operand mux for the granted station
  always_comb begin
    sel_oh  = '0;
    sel_any = 1'b0;
`ifdef ADDER_RS_AGE_EN
    best = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (ready_v[k] && (!sel_any || age[k] < best)) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        best      = age[k];
        sel_any   = 1'b1;
      end
    end
`else
    for (int k = 0; k < NUM_RS; k++) begin
      if (ready_v[k] && !sel_any) begin
        sel_oh[k] = 1'b1;
        sel_any   = 1'b1;
      end
    end
`endif
    grant_v = adder_ready ? sel_oh : '0;
    d_op = '0;
    d_a  = '0;
    d_b  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (sel_oh[k]) begin
        d_op = ent_op[k];
        d_a  = ent_vj[k];
        d_b  = ent_vk[k];
      end
    end
  end

  // Register status: rename on issue beats clearing by the CDB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) status[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (accept && Dest_address == 5'(r))
          status[r] <= free_tag;
        else if (cdb_valid && status[r] == cdb_tag)
          status[r] <= '0;
      end
    end
  end

  // Registered adder interface and per-station progress pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adder_start        <= 1'b0;
      adder_op           <= '0;
      adder_a            <= '0;
      adder_b            <= '0;
      adder_tag          <= '0;
      RS_issued          <= '0;
      RS_executing_adder <= '0;
      RS_finished        <= '0;
      issue_error        <= 1'b0;
    end else begin
      adder_start        <= |grant_v;
      RS_issued          <= accept ? free_tag : '0;
      RS_executing_adder <= TAG_W'(grant_v);
      RS_finished        <= TAG_W'(done_v);
      issue_error        <= reject;
      if (|grant_v) begin
        adder_op  <= d_op;
        adder_a   <= d_a;
        adder_b   <= d_b;
        adder_tag <= TAG_W'(grant_v);
      end
    end
  end

endmodule

// File: tb/tb_adder_reservation_stations.sv
// Bench for adder_reservation_stations: directed scenarios plus
// random traffic against a station/scoreboard reference model.
module tb_adder_reservation_stations;

  localparam int N = 3;
  localparam int S_FREE = 0, S_WAIT = 1, S_READY = 2, S_EXEC = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue = 1'b0;
  logic [5:0]  operation = '0;
  logic [4:0]  Dest_address = '0, A_address = '0, B_address = '0;
  logic [31:0] rf_a_data = '0, rf_b_data = '0;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        adder_ready = 1'b0;
  logic        adder_start;
  logic [2:0]  adder_op;
  logic [31:0] adder_a, adder_b;
  logic [5:0]  adder_tag, adder_RS_available;
  logic [5:0]  RS_issued, RS_executing_adder, RS_finished;
  logic        adder_available, issue_error;

  int total = 0;
  int bad = 0;

  int          m_st  [N];
  logic [31:0] m_vj  [N];
  logic [31:0] m_vk  [N];
  logic [5:0]  m_qj  [N];
  logic [5:0]  m_qk  [N];
  logic [2:0]  m_op  [N];
  int          m_seq [N];
  int          seq_ctr;
  logic [5:0]  m_stat [32];

  logic [5:0]  e_iss, e_fin, e_exec, e_tag;
  logic        e_err, e_start;
  logic [2:0]  e_op;
  logic [31:0] e_a, e_b;

  adder_reservation_stations dut (
    .clock              (clock),
    .reset              (reset),
    .issue              (issue),
    .operation          (operation),
    .Dest_address       (Dest_address),
    .A_address          (A_address),
    .B_address          (B_address),
    .rf_a_data          (rf_a_data),
    .rf_b_data          (rf_b_data),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .cdb_value          (cdb_value),
    .adder_ready        (adder_ready),
    .adder_start        (adder_start),
    .adder_op           (adder_op),
    .adder_a            (adder_a),
    .adder_b            (adder_b),
    .adder_tag          (adder_tag),
    .adder_available    (adder_available),
    .adder_RS_available (adder_RS_available),
    .RS_issued          (RS_issued),
    .RS_executing_adder (RS_executing_adder),
    .RS_finished        (RS_finished),
    .issue_error        (issue_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] lowest_free();
    for (int k = 0; k < N; k++)
      if (m_st[k] == S_FREE) return 6'(1) << k;
    return 6'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_st[k] = S_FREE;
    for (int r = 0; r < 32; r++) m_stat[r] = '0;
    seq_ctr = 0;
    e_iss = '0; e_fin = '0; e_exec = '0; e_err = 1'b0; e_start = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    int fr, pick;
    bit acc;
    logic [31:0] va, vb;
    logic [5:0] qa, qb;
    fr = -1;
    for (int k = 0; k < N; k++)
      if (m_st[k] == S_FREE && fr < 0) fr = k;
    acc = issue && operation[5:3] == 3'b000 && fr >= 0;
    qa = m_stat[A_address]; va = rf_a_data;
    if (qa != 0) begin
      if (cdb_valid && cdb_tag == qa) begin va = cdb_value; qa = 0; end
      else va = 0;
    end
    qb = m_stat[B_address]; vb = rf_b_data;
    if (qb != 0) begin
      if (cdb_valid && cdb_tag == qb) begin vb = cdb_value; qb = 0; end
      else vb = 0;
    end
    pick = -1;
    if (adder_ready)
      for (int k = 0; k < N; k++)
        if (m_st[k] == S_READY) begin
          if (pick < 0) pick = k;
`ifdef ADDER_RS_AGE_EN
          else if (m_seq[k] < m_seq[pick]) pick = k;
`endif
        end
    e_start = pick >= 0;
    e_exec = e_start ? 6'(1) << pick : 6'd0;
    if (e_start) begin
      e_op = m_op[pick]; e_a = m_vj[pick]; e_b = m_vk[pick];
      e_tag = 6'(1) << pick;
    end
    e_fin = 0;
    for (int k = 0; k < N; k++) begin
      if (m_st[k] == S_WAIT && cdb_valid) begin
        if (m_qj[k] != 0 && m_qj[k] == cdb_tag) begin
          m_vj[k] = cdb_value; m_qj[k] = 0;
        end
        if (m_qk[k] != 0 && m_qk[k] == cdb_tag) begin
          m_vk[k] = cdb_value; m_qk[k] = 0;
        end
        if (m_qj[k] == 0 && m_qk[k] == 0) m_st[k] = S_READY;
      end else if (m_st[k] == S_READY && pick == k) begin
        m_st[k] = S_EXEC;
      end else if (m_st[k] == S_EXEC && cdb_valid &&
                   cdb_tag == (6'(1) << k)) begin
        m_st[k] = S_FREE;
        e_fin[k] = 1'b1;
      end
    end
    for (int r = 0; r < 32; r++)
      if (cdb_valid && m_stat[r] == cdb_tag) m_stat[r] = 0;
    e_iss = 0;
    if (acc) begin
      m_st[fr] = (qa == 0 && qb == 0) ? S_READY : S_WAIT;
      m_vj[fr] = va; m_vk[fr] = vb; m_qj[fr] = qa; m_qk[fr] = qb;
      m_op[fr] = operation[2:0];
      m_seq[fr] = seq_ctr++;
      m_stat[Dest_address] = 6'(1) << fr;
      e_iss = 6'(1) << fr;
    end
    e_err = issue && !acc;
  endtask

  task automatic compare_all();
    check("issued", RS_issued, e_iss);
    check("issue_error", issue_error, e_err);
    check("finished", RS_finished, e_fin);
    check("executing", RS_executing_adder, e_exec);
    check("start", adder_start, e_start);
    if (e_start) begin
      check("op", adder_op, e_op);
      check("a", adder_a, e_a);
      check("b", adder_b, e_b);
      check("tag", adder_tag, e_tag);
    end
    check("available", adder_available, lowest_free() != 0);
    check("rs_available", adder_RS_available, lowest_free());
  endtask

  task automatic idle_inputs();
    issue = 0; cdb_valid = 0; adder_ready = 0;
  endtask

  task automatic cyc(input bit iss, input logic [5:0] op,
                     input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic [31:0] ra,
                     input logic [31:0] rb, input bit cv,
                     input logic [5:0] ct, input logic [31:0] cval,
                     input bit rdy);
    @(negedge clock);
    issue = iss; operation = op;
    Dest_address = d; A_address = a; B_address = b;
    rf_a_data = ra; rf_b_data = rb;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
    adder_ready = rdy;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] v);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, t, v, 0);
  endtask

  // Reset asserted away from any clock edge
  task automatic do_reset();
    idle_inputs();
    #3;
    reset = 1;
    model_reset();
    #1;
    compare_all();
    check("rst_start", adder_start, 0);
    check("rst_rs_avail", adder_RS_available, 6'b000001);
    @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    do_reset();

    // single add, dispatch, completion
    cyc(1, 6'o00, 2, 1, 4, 5, 7, 0, 0, 0, 0);
    check("t1_issued", RS_issued, 6'b000001);
    idle(1);
    check("t1_a", adder_a, 5);
    check("t1_b", adder_b, 7);
    check("t1_tag", adder_tag, 6'b000001);
    cdb(6'b000001, 12);
    check("t1_fin", RS_finished, 6'b000001);
    cyc(1, 6'o00, 3, 2, 2, 33, 33, 0, 0, 0, 0);
    idle(1);
    check("t1_r2_clear", adder_a, 33);
    cdb(6'b000001, 66);

    // dependency through the CDB
    do_reset();
    cyc(1, 6'o00, 2, 1, 4, 5, 7, 0, 0, 0, 0);
    cyc(1, 6'o01, 3, 2, 7, 99, 3, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 6'b000001, 12, 1);
    check("t2_no_early", adder_start, 0);
    idle(1);
    check("t2_a", adder_a, 12);
    check("t2_b", adder_b, 3);
    check("t2_tag", adder_tag, 6'b000010);
    check("t2_op", adder_op, 3'b001);

    // fill the bank
    do_reset();
    cyc(1, 6'o00, 3, 1, 2, 1, 2, 0, 0, 0, 0);
    cyc(1, 6'o07, 4, 1, 2, 3, 4, 0, 0, 0, 0);
    cyc(1, 6'o04, 5, 1, 2, 5, 6, 0, 0, 0, 0);
    check("t3_full_avail", adder_available, 0);
    check("t3_full_rsav", adder_RS_available, 0);
    cyc(1, 6'o00, 6, 1, 2, 7, 8, 0, 0, 0, 0);
    check("t3_err", issue_error, 1);
    check("t3_no_iss", RS_issued, 0);

    // same-cycle bypass at issue
    do_reset();
    cyc(1, 6'o00, 2, 1, 4, 5, 7, 0, 0, 0, 0);
    idle(1);
    cyc(1, 6'o00, 5, 2, 3, 77, 4, 1, 6'b000001, 9, 0);
    check("t4_fin", RS_finished, 6'b000001);
    idle(1);
    check("t4_start", adder_start, 1);
    check("t4_a", adder_a, 9);
    check("t4_tag", adder_tag, 6'b000010);

    // non-adder unit
    do_reset();
    cyc(1, 6'o10, 2, 1, 1, 1, 1, 0, 0, 0, 0);
    check("t5_err", issue_error, 1);
    check("t5_no_iss", RS_issued, 0);

    // reset with stations in flight
    do_reset();
    cyc(1, 6'o00, 2, 1, 4, 5, 7, 0, 0, 0, 0);
    idle(1);
    cyc(1, 6'o00, 6, 2, 3, 0, 1, 0, 0, 0, 0);
    do_reset();
    cdb(6'b000001, 12);
    check("t6_no_fin", RS_finished, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit iss, cv;
      logic [5:0] op, ct;
      int ex [$];
      iss = $urandom_range(0, 9) < 4;
      op = {($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000,
            3'($urandom)};
      cv = $urandom_range(0, 1);
      for (int k = 0; k < N; k++) if (m_st[k] == S_EXEC) ex.push_back(k);
      if (ex.size() > 0 && $urandom_range(0, 9) < 7)
        ct = 6'(1) << ex[$urandom_range(0, ex.size() - 1)];
      else
        ct = 6'(1) << $urandom_range(0, 5);
      cyc(iss, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), $urandom, $urandom, cv, ct, $urandom,
          $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
